// File: rtl/float_addsub_sequencer.sv
// float_addsub_sequencer: sequences single-precision add/sub requests into an external adder core,
// short-circuiting special operands and bounding the wait for the core's result.
module float_addsub_sequencer #(
   parameter int TIMEOUT_CYC = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_op,
   output logic        core_signA,
   output logic [7:0]  core_expA,
   output logic [22:0] core_mantA,
   output logic        core_signB,
   output logic [7:0]  core_expB,
   output logic [22:0] core_mantB,
   output logic        core_op,
   output logic        core_load,
   input  logic        core_signOut,
   input  logic [7:0]  core_expOut,
   input  logic [22:0] core_mantOut,
   input  logic        core_valid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [1:0]  out_flags
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [2:0] {IDLE, CLASSIFY, LOAD0, LOAD1, WAIT, DONE} state_t;

   state_t        state;
   logic [31:0]   a_reg, b_reg;
   logic          op_reg;
   logic [CW-1:0] cnt;

   logic        sa, sb, nan_a, nan_b, inf_a, inf_b, z_a, z_b, same_mag, byp;
   logic [31:0] eff_b, byp_res;

   assign in_ready   = state == IDLE;
   assign core_signA = a_reg[31];
   assign core_expA  = a_reg[30:23];
   assign core_mantA = a_reg[22:0];
   assign core_signB = b_reg[31];
   assign core_expB  = b_reg[30:23];
   assign core_mantB = b_reg[22:0];
   assign core_op    = op_reg;

   assign sa       = a_reg[31];
   assign sb       = b_reg[31] ^ op_reg;
   assign eff_b    = {sb, b_reg[30:0]};
   assign nan_a    = a_reg[30:23] == 8'hFF && a_reg[22:0] != '0;
   assign nan_b    = b_reg[30:23] == 8'hFF && b_reg[22:0] != '0;
   assign inf_a    = a_reg[30:23] == 8'hFF && a_reg[22:0] == '0;
   assign inf_b    = b_reg[30:23] == 8'hFF && b_reg[22:0] == '0;
   assign z_a      = a_reg[30:23] == 8'h00;
   assign z_b      = b_reg[30:23] == 8'h00;
   assign same_mag = a_reg[30:0] == b_reg[30:0] && sa != sb;
   assign byp      = nan_a | nan_b | inf_a | inf_b | z_a | z_b | same_mag;

   // Priority order matters: NaN, then inf conflicts, then zeros, then exact cancellation.
   assign byp_res = (nan_a | nan_b | (inf_a & inf_b & (sa != sb))) ? QNAN :
                    inf_a       ? a_reg :
                    inf_b       ? eff_b :
                    (z_a & z_b) ? 32'h0 :
                    z_a         ? eff_b :
                    z_b         ? a_reg : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= 1'b0;
         cnt        <= '0;
         core_load  <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_reg  <= in_a;
               b_reg  <= in_b;
               op_reg <= in_op;
               state  <= CLASSIFY;
            end
            CLASSIFY: if (byp) begin
               out_result <= byp_res;
               out_flags  <= 2'b01;
               out_valid  <= 1'b1;
               state      <= DONE;
            end else begin
               core_load <= 1'b1;
               state     <= LOAD0;
            end
            LOAD0: state <= LOAD1;
            LOAD1: begin
               core_load <= 1'b0;
               cnt       <= '0;
               state     <= WAIT;
            end
            WAIT: if (core_valid) begin
               out_result <= core_expOut == 8'hFF ? {core_signOut, 8'hFF, 23'h0}
                                                  : {core_signOut, core_expOut, core_mantOut};
               out_flags  <= 2'b00;
               out_valid  <= 1'b1;
               state      <= DONE;
            end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
               out_result <= QNAN;
               out_flags  <= 2'b10;
               out_valid  <= 1'b1;
               state      <= DONE;
            end else begin
               cnt <= cnt + 1'b1;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_float_addsub_sequencer.sv
// tb_float_addsub_sequencer: randomized requests against a transaction-level model of
// classification, core hand-off, timeout and output handshake timing.
module tb_float_addsub_sequencer;
   localparam int TO = 63;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_op;
   logic [31:0] in_a, in_b;
   logic        core_signA, core_signB, core_op, core_load;
   logic [7:0]  core_expA, core_expB;
   logic [22:0] core_mantA, core_mantB;
   logic        core_signOut, core_valid;
   logic [7:0]  core_expOut;
   logic [22:0] core_mantOut;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic [1:0]  out_flags;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] sp [10] = '{32'h00000000, 32'h80000000, 32'h00012345, 32'h7F800000, 32'hFF800000,
                            32'h7FC00001, 32'hFF800001, 32'h3F800000, 32'hBF800000, 32'h40A00000};

   always #5 clk = ~clk;

   float_addsub_sequencer #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .core_signA(core_signA), .core_expA(core_expA), .core_mantA(core_mantA),
      .core_signB(core_signB), .core_expB(core_expB), .core_mantB(core_mantB),
      .core_op(core_op), .core_load(core_load),
      .core_signOut(core_signOut), .core_expOut(core_expOut), .core_mantOut(core_mantOut),
      .core_valid(core_valid), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Returns {is_bypass, bypass_result} straight from the operand classification rules.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
      logic [31:0] eb;
      bit na, nb, ia, ib, za, zb;
      eb = b ^ {op, 31'h0};
      na = a[30:23] == 8'hFF && a[22:0] != 0;
      nb = b[30:23] == 8'hFF && b[22:0] != 0;
      ia = a[30:23] == 8'hFF && a[22:0] == 0;
      ib = b[30:23] == 8'hFF && b[22:0] == 0;
      za = a[30:23] == 0;
      zb = b[30:23] == 0;
      if (na || nb) return {1'b1, 32'h7FC00000};
      if (ia && ib && a[31] != eb[31]) return {1'b1, 32'h7FC00000};
      if (ia) return {1'b1, a};
      if (ib) return {1'b1, eb};
      if (za && zb) return {1'b1, 32'h0};
      if (za) return {1'b1, eb};
      if (zb) return {1'b1, a};
      if (a[30:0] == b[30:0] && a[31] != eb[31]) return {1'b1, 32'h0};
      return {1'b0, 32'h0};
   endfunction

   function automatic logic [31:0] core_fix(input logic [31:0] r);
      return r[30:23] == 8'hFF ? {r[31], 8'hFF, 23'h0} : r;
   endfunction

   // dly: WAIT cycle index at which the core answers (<0 = never); hold: DONE cycles with out_ready low.
   task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input int dly, input logic [31:0] cres, input int hold);
      logic [32:0] m;
      logic [31:0] er;
      logic [1:0]  ef;
      bit byp, ok;
      int lat;
      m   = model(a, b, op);
      byp = m[32];
      ok  = dly >= 0 && dly < TO;
      lat = byp ? 2 : ok ? 5 + dly : 4 + TO;
      er  = byp ? m[31:0] : ok ? core_fix(cres) : 32'h7FC00000;
      ef  = byp ? 2'b01 : ok ? 2'b00 : 2'b10;
      chk("in_ready idle", in_ready, 1);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; out_ready = 1'b0;
      step();
      for (int c = 1; c <= lat; c++) begin
         chk("core_load", core_load, !byp && (c == 2 || c == 3));
         chk("in_ready busy", in_ready, 0);
         chk("out_valid timing", out_valid, c == lat);
         if (!byp && c >= 2) begin
            chk("core A fields", {core_signA, core_expA, core_mantA}, a);
            chk("core B fields", {core_signB, core_expB, core_mantB}, b);
            chk("core_op", core_op, op);
         end
         in_valid = 1'($urandom); in_a = $urandom; in_b = $urandom; in_op = 1'($urandom);
         out_ready = c < lat ? 1'($urandom) : 1'b0;
         core_valid = !byp && dly >= 0 && c == 4 + dly;
         {core_signOut, core_expOut, core_mantOut} = core_valid ? cres : $urandom;
         if (c < lat) step();
      end
      for (int h = 0; h <= hold; h++) begin
         chk("out_result", out_result, er);
         chk("out_flags", out_flags, ef);
         chk("out_valid held", out_valid, 1);
         chk("in_ready in done", in_ready, 0);
         core_valid = 1'b0;
         out_ready = h == hold;
         in_valid = h == hold ? 1'b0 : 1'($urandom);
         step();
      end
      out_ready = 1'b0;
      chk("out_valid after hs", out_valid, 0);
      chk("in_ready after hs", in_ready, 1);
      chk("core_load after hs", core_load, 0);
      if (!byp) chk("core A stable", {core_signA, core_expA, core_mantA}, a);
   endtask

   initial begin
      logic [31:0] a, b, cres;
      int r, dly;
      rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 0;
      core_valid = 0; core_signOut = 0; core_expOut = 0; core_mantOut = 0;
      step();
      step();
      rst = 1'b0;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset core_load", core_load, 0);
      chk("reset out_result", out_result, 0);
      chk("reset out_flags", out_flags, 0);
      chk("reset core A", {core_signA, core_expA, core_mantA}, 0);

      chk("pin 1+2 core", model(32'h3F800000, 32'h40000000, 0), 33'h0_00000000);
      chk("pin 5-5", model(32'h40A00000, 32'h40A00000, 1), 33'h1_00000000);
      chk("pin inf-inf", model(32'h7F800000, 32'hFF800000, 0), 33'h1_7FC00000);
      chk("pin 0-1", model(32'h00000000, 32'h3F800000, 1), 33'h1_BF800000);
      chk("pin core inf", core_fix(32'hFF812345), 32'hFF800000);

      do_req(32'h3F800000, 32'h40000000, 0, 2, 32'h40400000, 0);
      do_req(32'h40A00000, 32'h40A00000, 1, 0, 32'h0, 0);
      do_req(32'h7F800000, 32'hFF800000, 0, 0, 32'h0, 1);
      do_req(32'h00000000, 32'h3F800000, 1, 0, 32'h0, 0);
      do_req(32'h3F800000, 32'h40000000, 0, -1, 32'h0, 0);
      do_req(32'h3F800000, 32'h40000000, 1, 62, 32'h12345678, 0);
      do_req(32'h3F800000, 32'h40000000, 0, 3, 32'h7F812345, 10);

      in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst mid out_valid", out_valid, 0);
      chk("rst mid in_ready", in_ready, 1);
      chk("rst mid core_load", core_load, 0);
      chk("rst mid core B", {core_signB, core_expB, core_mantB}, 0);
      core_valid = 1'b1; {core_signOut, core_expOut, core_mantOut} = 32'h40400000;
      step();
      core_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late core_valid ignored", out_valid, 0);
         chk("late in_ready", in_ready, 1);
         step();
      end
      do_req(32'h40400000, 32'h3F800000, 1, 1, 32'h40000000, 0);

      for (int t = 0; t < 150; t++) begin
         a = $urandom_range(0, 2) == 0 ? sp[$urandom_range(0, 9)] : $urandom;
         if ($urandom_range(0, 4) == 0) b = a ^ ($urandom_range(0, 1) ? 32'h80000000 : 32'h0);
         else b = $urandom_range(0, 2) == 0 ? sp[$urandom_range(0, 9)] : $urandom;
         r = $urandom_range(0, 19);
         dly = r == 0 ? -1 : r == 1 ? 62 : r == 2 ? 63 : $urandom_range(0, 8);
         cres = $urandom;
         if ($urandom_range(0, 4) == 0) cres[30:23] = 8'hFF;
         do_req(a, b, 1'($urandom), dly, cres, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/float_addsub_sequencer.md
FLOAT_ADDSUB_SEQUENCER -- requirements
Module: float_addsub_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 63: maximum number of WAIT cycles allowed for core_valid.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  sequencer accepts a request.
REQ-006 in_a / in_b  in  32 each  IEEE-754 single-precision operands.
REQ-007 in_op  in  1  0 = A+B, 1 = A-B.
REQ-008 core_signA, core_expA, core_mantA  out  1/8/23  operand-A fields to the adder core.
REQ-009 core_signB, core_expB, core_mantB  out  1/8/23  operand-B fields to the adder core.
REQ-010 core_op, core_load  out  1 each  operation select and load strobe to the core.
REQ-011 core_signOut, core_expOut, core_mantOut, core_valid  in  1/8/23/1  core result and its valid flag.
REQ-012 out_valid  out  1  result present; out_ready  in  1  consumer accepts.
REQ-013 out_result  out  32  packed IEEE result; out_flags  out  2  [0] = bypass, [1] = timeout.

Function
REQ-014 FSM states SHALL be IDLE, CLASSIFY, LOAD0, LOAD1, WAIT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE with in_valid=1 SHALL capture in_a, in_b and in_op into internal registers and move to CLASSIFY.
REQ-016 In CLASSIFY, effB SHALL equal in_b with its sign XOR op; an operand with exp==0 SHALL be treated as zero (denormals flushed).
REQ-017 CLASSIFY bypass rules, in priority order:
- any NaN (exp 255, mant != 0) -> 0x7FC00000;
- inf and inf of opposite effective sign -> 0x7FC00000;
- a single inf -> that inf, sign taken from effB when it is B;
- both zero -> 0x00000000;
- one zero -> the other operand, with effB's sign when it is B;
- equal exp and mant with opposite effective sign -> 0x00000000.
REQ-018 Every bypass SHALL go directly to DONE with out_flags=2'b01 and SHALL NOT assert core_load.
REQ-019 All other cases SHALL proceed to LOAD0.
REQ-020 core_load SHALL be 1 in both LOAD0 and LOAD1 (exactly two consecutive cycles) and 0 in every other state.
REQ-021 core_* operand outputs and core_op SHALL come from the captured registers and stay stable from LOAD0 until the next capture.
REQ-022 The LOAD0->LOAD1->WAIT transitions SHALL be unconditional.
REQ-023 WAIT SHALL count cycles from 0; the counter SHALL reset to 0 on entry.
REQ-024 In WAIT, core_valid=1 SHALL move to DONE with out_result={core_signOut, core_expOut, core_mantOut} and out_flags=2'b00.
REQ-025 If that captured exponent is 8'hFF, out_result SHALL be forced to signed inf (mantissa 0).
REQ-026 If the counter reaches TIMEOUT_CYC without core_valid, WAIT SHALL move to DONE with out_result=0x7FC00000 and out_flags=2'b10.
REQ-027 If core_valid and timeout occur in the same cycle, core_valid SHALL win.
REQ-028 DONE SHALL assert out_valid and hold out_result and out_flags stable until out_ready=1.
REQ-029 On that handshake cycle the FSM SHALL return to IDLE and deassert out_valid on the next cycle.
REQ-030 Latency: bypass requests SHALL present out_valid 2 cycles after capture; core requests SHALL present it at (core cycles + 4).
REQ-031 in_valid SHALL be ignored in every state except IDLE.

Reset
REQ-032 rst=1 SHALL, on the next clock edge and in any state, force IDLE and clear out_valid, core_load, out_result, out_flags, the counter and the captured registers.
REQ-033 A request in flight when reset arrives SHALL be discarded and no out_valid produced for it; the core is not reset, and its late core_valid SHALL be ignored in IDLE.

Verification
REQ-034 1.0+2.0 (0x3F800000, 0x40000000, op=0), core model returns 0x40400000 -> out_result=0x40400000, flags=00, core_load high exactly 2 cycles.
REQ-035 5.0-5.0 (0x40A00000 twice, op=1) -> no core_load, out_result=0x00000000, flags=01, out_valid 2 cycles after capture.
REQ-036 +inf + -inf (0x7F800000, 0xFF800000, op=0) -> 0x7FC00000, flags=01; 0x00000000-0x3F800000 -> 0xBF800000, flags=01.
REQ-037 Core model never raises core_valid -> out_result=0x7FC00000, flags=10 after TIMEOUT_CYC WAIT cycles.
REQ-038 out_ready held 0 for 10 cycles in DONE -> out_valid and out_result stable, in_ready=0, new in_valid ignored; in_ready=1 the cycle after the handshake.
REQ-039 rst pulsed in WAIT, then core_valid arrives -> out_valid stays 0, in_ready=1, the next request completes normally.
